// File: rtl/mul_acc_unit.sv
// mul_acc_unit: byte-serial 32x32 multiplier with HI/LO accumulator (MULT/MADD/MSUB/MUL, MTHI/MTLO, MFHI/MFLO).
module mul_acc_unit (
  input  logic        clk,
  input  logic        nrst,
  input  logic        Valid,
  input  logic        ALUOp,
  input  logic        MULOp,
  input  logic        ACCEn,
  input  logic        MULSelB,
  input  logic        Flush,
  input  logic [5:0]  Func,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic [1:0] {IDLE, CALC, ACC} state_t;
  typedef enum logic [1:0] {OP_MULT, OP_MADD, OP_MSUB, OP_MUL} op_t;
  state_t state, state_d;
  op_t op, op_d;
  logic [31:0] hi_q, lo_q, mul_res, b_sh;
  logic [63:0] a_sh, prod, p, hilo_new;
  logic [1:0] cnt;
  logic neg, mt_done, commit;
  logic is_mult, is_multu, is_madd, is_maddu, is_msub, is_msubu, is_mul, is_mthi, is_mtlo;
  logic launch, go_mul, go_mt, sgn;
  assign is_mult  = ALUOp & (Func == 6'b011000);
  assign is_multu = ALUOp & (Func == 6'b011001);
  assign is_mthi  = ALUOp & (Func == 6'b010001);
  assign is_mtlo  = ALUOp & (Func == 6'b010011);
  assign is_madd  = MULOp & (Func == 6'b000000);
  assign is_maddu = MULOp & (Func == 6'b000001);
  assign is_mul   = MULOp & (Func == 6'b000010);
  assign is_msub  = MULOp & (Func == 6'b000100);
  assign is_msubu = MULOp & (Func == 6'b000101);
  assign launch = Valid & (state == IDLE) & ~Flush & (ACCEn | is_mul);
  assign go_mul = launch & (is_mult | is_multu | is_madd | is_maddu | is_msub | is_msubu | is_mul);
  assign go_mt  = launch & ~MULSelB & (is_mthi | is_mtlo);
  assign sgn    = is_mult | is_madd | is_msub | is_mul;
  assign op_d   = (is_mult | is_multu) ? OP_MULT : (is_madd | is_maddu) ? OP_MADD :
                  (is_msub | is_msubu) ? OP_MSUB : OP_MUL;
  always_comb begin
    state_d = state;
    state_d = (Flush && state != IDLE) ? IDLE :
              (state == IDLE) ? (go_mul ? CALC : IDLE) :
              (state == CALC) ? ((cnt == 2'd3) ? ACC : CALC) : IDLE;
  end
  // The accumulator update is shown combinationally during ACC and committed at its closing edge, so a Flush in ACC can still cancel it.
  always_comb begin
    p = neg ? -prod : prod;
    hilo_new = (op == OP_MULT) ? p :
               (op == OP_MADD) ? {hi_q, lo_q} + p :
               (op == OP_MSUB) ? {hi_q, lo_q} - p : {hi_q, lo_q};
  end
  assign commit = (state == ACC) & ~Flush;
  assign HI     = commit ? hilo_new[63:32] : hi_q;
  assign LO     = commit ? hilo_new[31:0] : lo_q;
  assign Busy   = (state == CALC);
  assign Done   = commit | mt_done;
  assign Result = (ALUOp && Func == 6'b010000) ? HI : (ALUOp && Func == 6'b010010) ? LO : mul_res;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      op <= OP_MULT;
      hi_q <= '0;
      lo_q <= '0;
      mul_res <= '0;
      a_sh <= '0;
      b_sh <= '0;
      prod <= '0;
      cnt <= '0;
      neg <= 1'b0;
      mt_done <= 1'b0;
    end else begin
      state <= state_d;
      mt_done <= go_mt;
      if (go_mt && is_mthi) hi_q <= A;
      if (go_mt && is_mtlo) lo_q <= A;
      if (go_mul) begin
        a_sh <= {32'b0, (sgn && A[31]) ? -A : A};
        b_sh <= (sgn && B[31]) ? -B : B;
        prod <= '0;
        cnt <= '0;
        neg <= sgn & (A[31] ^ B[31]);
        op <= op_d;
      end else if (state == CALC) begin
        prod <= prod + a_sh * 64'(b_sh[7:0]);
        a_sh <= a_sh << 8;
        b_sh <= b_sh >> 8;
        cnt <= cnt + 2'd1;
      end
      if (commit) begin
        {hi_q, lo_q} <= hilo_new;
        if (op == OP_MUL) mul_res <= p[31:0];
      end
    end
  end
endmodule
